// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into little-endian words,
// writes them into the instruction RAM and releases the CPU after the EOF word.
module imem_loader #(
  parameter int DEPTH  = 56,
  parameter int ADDR_W = 6
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_index,
  output logic [31:0]       mem_entry,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow_err,
  output logic              cpu_rstn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       EOF_WORD = 32'hFFFF_FFFF;

  state_t              r_state, w_state;
  logic [1:0]          r_byte_cnt, w_byte_cnt;
  logic [31:0]         r_asm, w_asm;
  logic                r_s_ready, w_s_ready;
  logic                r_wr_en, w_wr_en;
  logic [ADDR_W-1:0]   r_index, w_index;
  logic [31:0]         r_entry, w_entry;
  logic [ADDR_W:0]     r_count, w_count;
  logic                r_done, w_done;
  logic                r_ovf, w_ovf;
  logic                r_cpu_rstn, w_cpu_rstn;
  logic                w_accept;

  assign w_accept = s_valid && r_s_ready;

  always_comb begin
    w_state    = r_state;
    w_byte_cnt = r_byte_cnt;
    w_asm      = r_asm;
    w_s_ready  = r_s_ready;
    w_wr_en    = 1'b0;
    w_index    = r_index;
    w_entry    = r_entry;
    w_count    = r_count;
    w_done     = r_done;
    w_ovf      = r_ovf;
    w_cpu_rstn = r_cpu_rstn;
    unique case (r_state)
      S_RECV: begin
        if (w_accept) begin
          w_asm[{r_byte_cnt, 3'b000} +: 8] = s_data;
          w_byte_cnt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_state   = S_WRITE;
            w_s_ready = 1'b0;
            w_wr_en   = 1'b1;
            w_entry   = w_asm;
            w_count   = r_count + 1'b1;
          end
        end
      end
      S_WRITE: begin
        // EOF word is written too: the CPU stops when it fetches it
        if (r_entry == EOF_WORD) begin
          w_state    = S_DONE;
          w_done     = 1'b1;
          w_cpu_rstn = 1'b1;
        end else if (r_index == LAST_IDX) begin
          w_state = S_ERROR;
          w_ovf   = 1'b1;
        end else begin
          w_state    = S_RECV;
          w_index    = r_index + 1'b1;
          w_byte_cnt = 2'd0;
          w_asm      = 32'd0;
          w_s_ready  = 1'b1;
        end
      end
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state    = S_RECV;
          w_byte_cnt = 2'd0;
          w_asm      = 32'd0;
          w_index    = '0;
          w_count    = '0;
          w_done     = 1'b0;
          w_ovf      = 1'b0;
          w_cpu_rstn = 1'b0;
          w_s_ready  = 1'b1;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_s_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_asm      <= 32'd0;
      r_s_ready  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_index    <= '0;
      r_entry    <= 32'd0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_cpu_rstn <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_byte_cnt <= w_byte_cnt;
      r_asm      <= w_asm;
      r_s_ready  <= w_s_ready;
      r_wr_en    <= w_wr_en;
      r_index    <= w_index;
      r_entry    <= w_entry;
      r_count    <= w_count;
      r_done     <= w_done;
      r_ovf      <= w_ovf;
      r_cpu_rstn <= w_cpu_rstn;
    end
  end

  assign s_ready      = r_s_ready;
  assign mem_wr_en    = r_wr_en;
  assign mem_index    = r_index;
  assign mem_entry    = r_entry;
  assign word_count   = r_count;
  assign load_done    = r_done;
  assign overflow_err = r_ovf;
  assign cpu_rstn     = r_cpu_rstn;

endmodule
